// File: rtl/fnd_scan_driver.sv
`default_nettype none
//==============================================================================
// Module   : fnd_scan_driver
// Purpose  : Drives a 4-digit, common-anode, multiplexed 7-segment (FND)
//            display. It converts a 14-bit binary value to four BCD digits
//            with a 16-cycle double-dabble FSM, then scans the digits at
//            SCAN_DIV clk cycles per digit.
// Ports    : clk      - system clock, rising edge
//            reset    - asynchronous, active-high reset
//            counter  - 14-bit unsigned value to display (saturates at 9999)
//            fnd_com  - active-low one-hot digit enable (bit0 = ones)
//            fnd_data - active-low segments {dp,g,f,e,d,c,b,a}
// Options  : `define FND_LEADING_ZERO_BLANK_EN to blank leading zeros on
//            digits 3..1. Digit 0 is never blanked.
// Revision : 1.0 - initial release
//==============================================================================
module fnd_scan_driver #(
    parameter int SCAN_DIV = 100_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] counter,
    output logic [3:0]  fnd_com,
    output logic [7:0]  fnd_data
);

    localparam int                 c_PRE_W   = $clog2(SCAN_DIV);
    localparam logic [c_PRE_W-1:0] c_PRE_MAX = c_PRE_W'(SCAN_DIV - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_CONV = 2'd1;
    localparam logic [1:0] c_ST_LOAD = 2'd2;

    // Working register: [29:14] holds the BCD accumulator, [13:0] the binary
    // operand, which is shifted out MSB first into the BCD LSB.
    logic [1:0]         r_state;
    logic [3:0]         r_bit_cnt;
    logic [29:0]        r_work;
    logic [15:0]        r_disp;
    logic [c_PRE_W-1:0] r_pre;
    logic [1:0]         r_digit;
    logic [3:0]         r_com;
    logic [7:0]         r_data;

    logic [13:0] w_sat;
    logic [29:0] w_adj;
    logic [29:0] w_work_step;
    logic        w_load;
    logic        w_tick;
    logic [15:0] w_disp_nxt;
    logic [1:0]  w_digit_nxt;
    logic [3:0]  w_nib;
    logic        w_blank;
    logic [7:0]  w_seg;

    assign w_sat = (counter > 14'd9999) ? 14'd9999 : counter;

    // One double-dabble step: correct every BCD nibble >= 5, then shift.
    always_comb begin
        w_adj = r_work;
        for (int i = 0; i < 4; i++) begin
            if (r_work[14 + 4*i +: 4] >= 4'd5) begin
                w_adj[14 + 4*i +: 4] = r_work[14 + 4*i +: 4] + 4'd3;
            end
        end
    end

    assign w_work_step = w_adj << 1;

    // Converter FSM: IDLE (sample) -> CONV (14 steps) -> LOAD (publish).
    // The input is sampled only in IDLE, so changes during CONV cannot
    // disturb the conversion in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= c_ST_IDLE;
            r_bit_cnt <= 4'd0;
            r_work    <= 30'd0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_work    <= {16'd0, w_sat};
                    r_bit_cnt <= 4'd0;
                    r_state   <= c_ST_CONV;
                end
                c_ST_CONV: begin
                    r_work    <= w_work_step;
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                    if (r_bit_cnt == 4'd13) begin
                        r_state <= c_ST_LOAD;
                    end
                end
                c_ST_LOAD: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign w_load     = (r_state == c_ST_LOAD);
    assign w_disp_nxt = w_load ? r_work[29:14] : r_disp;

    // Scan prescaler and digit index.
    assign w_tick      = (r_pre == c_PRE_MAX);
    assign w_digit_nxt = w_tick ? (r_digit + 2'd1) : r_digit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pre   <= '0;
            r_digit <= 2'd0;
            r_disp  <= 16'd0;
        end else begin
            r_pre   <= w_tick ? '0 : (r_pre + c_PRE_W'(1));
            r_digit <= w_digit_nxt;
            r_disp  <= w_disp_nxt;
        end
    end

    // Outputs are decoded from the next-state digit index and display value
    // so that the registered outputs line up with the same edge that moves
    // the index or loads the display, with no extra cycle of lag.
    always_comb begin
        w_nib   = w_disp_nxt[{w_digit_nxt, 2'b00} +: 4];
        w_blank = 1'b0;
`ifdef FND_LEADING_ZERO_BLANK_EN
        case (w_digit_nxt)
            2'd3:    w_blank = (w_disp_nxt[15:12] == 4'd0);
            2'd2:    w_blank = (w_disp_nxt[15:8]  == 8'd0);
            2'd1:    w_blank = (w_disp_nxt[15:4]  == 12'd0);
            default: w_blank = 1'b0;
        endcase
`endif
        case (w_nib)
            4'd0:    w_seg = 8'hC0;
            4'd1:    w_seg = 8'hF9;
            4'd2:    w_seg = 8'hA4;
            4'd3:    w_seg = 8'hB0;
            4'd4:    w_seg = 8'h99;
            4'd5:    w_seg = 8'h92;
            4'd6:    w_seg = 8'h82;
            4'd7:    w_seg = 8'hF8;
            4'd8:    w_seg = 8'h80;
            4'd9:    w_seg = 8'h90;
            default: w_seg = 8'hFF;
        endcase
        if (w_blank) begin
            w_seg = 8'hFF;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_com  <= 4'b1110;
            r_data <= 8'hC0;
        end else begin
            r_com  <= ~(4'b0001 << w_digit_nxt);
            r_data <= w_seg;
        end
    end

    assign fnd_com  = r_com;
    assign fnd_data = r_data;

endmodule
`default_nettype wire

// File: tb/tb_fnd_scan_driver.sv
`default_nettype none
//==============================================================================
// Module   : tb_fnd_scan_driver
// Purpose  : Self-checking bench for fnd_scan_driver with SCAN_DIV = 4.
//            Table vectors, timed reset / mid-conversion sequences, scan
//            cadence, and random values against a decimal reference model.
// Options  : honours FND_LEADING_ZERO_BLANK_EN like the design.
// Revision : 1.0 - initial release
//==============================================================================
module tb_fnd_scan_driver;

    localparam int SCAN_DIV = 4;

`ifdef FND_LEADING_ZERO_BLANK_EN
    localparam logic [7:0] LZ = 8'hFF;
`else
    localparam logic [7:0] LZ = 8'hC0;
`endif

    typedef struct {
        logic [13:0]      cnt;
        logic [3:0][7:0]  seg;   // seg[d] = expected fnd_data for digit d
        string            name;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [13:0] counter;
    logic [3:0]  fnd_com;
    logic [7:0]  fnd_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fnd_scan_driver #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk      (clk),
        .reset    (reset),
        .counter  (counter),
        .fnd_com  (fnd_com),
        .fnd_data (fnd_data)
    );

    // ---------------- reference model ----------------
    function automatic logic [7:0] seg_of(input int d);
        case (d)
            0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;
            3: return 8'hB0;  4: return 8'h99;  5: return 8'h92;
            6: return 8'h82;  7: return 8'hF8;  8: return 8'h80;
            9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [7:0] model_seg(input int value, input int idx);
        int v;
        int p;
        v = (value > 9999) ? 9999 : value;
        p = 1;
        for (int i = 0; i < idx; i++) p = p * 10;
`ifdef FND_LEADING_ZERO_BLANK_EN
        if (idx > 0 && v < p) return 8'hFF;
`endif
        return seg_of((v / p) % 10);
    endfunction

    function automatic logic [3:0] model_com(input int idx);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << idx);
    endfunction

    function automatic int com_idx(input logic [3:0] c);
        case (c)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return -1;
        endcase
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply a value, let it settle (<= 32 cycles), then watch one full scan.
    task automatic observe(input logic [13:0] val, input logic [3:0][7:0] exp, input string name);
        int idx;
        counter = val;
        repeat (40) @(negedge clk);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            idx = com_idx(fnd_com);
            if (idx < 0) begin
                checks++;
                errors++;
                $display("FAIL %s_com: got %b, expected a one-hot-low pattern", name, fnd_com);
            end else begin
                check8($sformatf("%s_d%0d", name, idx), fnd_data, exp[idx]);
            end
        end
    endtask

    // Expected display contents k edges after reset release in the timed
    // sequence: 0 until the first LOAD, then 5, then 9998.
    function automatic int disp_at(input int k);
        if (k < 16) return 0;
        if (k < 32) return 5;
        return 9998;
    endfunction

    vec_t vecs[6];

    initial begin
        int              d;
        int              n;
        int              len;
        int              v;
        logic [3:0]      cur;
        logic [3:0]      prev;
        logic [3:0][7:0] mexp;

        vecs[0] = '{14'd0,      {LZ,    LZ,    LZ,    8'hC0}, "zero"};
        vecs[1] = '{14'd1234,   {8'hF9, 8'hA4, 8'hB0, 8'h99}, "v1234"};
        vecs[2] = '{14'd9999,   {8'h90, 8'h90, 8'h90, 8'h90}, "v9999"};
        vecs[3] = '{14'h3FFF,   {8'h90, 8'h90, 8'h90, 8'h90}, "sat3fff"};
        vecs[4] = '{14'd7,      {LZ,    LZ,    LZ,    8'hF8}, "v7"};
        vecs[5] = '{14'd105,    {LZ,    8'hF9, 8'hC0, 8'h92}, "v105"};

        // ---------- reset asserted mid-CONV ----------
        reset   = 1'b1;
        counter = 14'd1234;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (42) @(posedge clk);     // edges 34..47 are CONV of 3rd pass
        #2;
        check8("pre_reset_com",  {4'h0, fnd_com}, {4'h0, model_com(2)});
        check8("pre_reset_data", fnd_data, model_seg(1234, 2));
        reset = 1'b1;                    // asynchronous, between edges
        #1;
        check8("async_reset_com",  {4'h0, fnd_com}, 8'h0E);
        check8("async_reset_data", fnd_data, 8'hC0);

        // ---------- release, then change input during CONV ----------
        counter = 14'd5;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check8("release_com",  {4'h0, fnd_com}, 8'h0E);
        check8("release_data", fnd_data, 8'hC0);
        for (int k = 1; k <= 48; k++) begin
            @(posedge clk);
            if (k == 3) begin
                #1;
                counter = 14'd9998;
            end
            @(negedge clk);
            d = (k / SCAN_DIV) % 4;
            check8($sformatf("midconv_com_k%0d", k), {4'h0, fnd_com}, {4'h0, model_com(d)});
            check8($sformatf("midconv_data_k%0d", k), fnd_data, model_seg(disp_at(k), d));
        end

        // ---------- table vectors ----------
        for (int i = 0; i < 6; i++) begin
            observe(vecs[i].cnt, vecs[i].seg, vecs[i].name);
        end

        // ---------- scan cadence and wrap ----------
        @(negedge clk);
        prev = fnd_com;
        n = 0;
        while (fnd_com == prev && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 10) begin
            errors++;
            $display("FAIL scan_sync: fnd_com stuck at %b for %0d cycles", fnd_com, n);
        end
        for (int r = 0; r < 8; r++) begin
            cur = fnd_com;
            len = 0;
            while (fnd_com == cur && len < 10) begin
                @(negedge clk);
                len++;
            end
            check8($sformatf("scan_len_%0d", r), 8'(len), 8'(SCAN_DIV));
            check8($sformatf("scan_next_%0d", r), {4'h0, fnd_com}, {4'h0, cur[2:0], cur[3]});
        end

        // ---------- random values against the model ----------
        for (int i = 0; i < 12; i++) begin
            v = (i % 4 == 3) ? int'($urandom_range(9990, 16383)) : int'($urandom_range(0, 16383));
            for (int j = 0; j < 4; j++) mexp[j] = model_seg(v, j);
            observe(14'(v), mexp, $sformatf("rand%0d_%0d", i, v));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
